// File: rtl/mc_ctrl_unit_if.sv
// Control-unit <-> datapath bundle: latched opcode and ALU flags in, decoded controls out.
// Purely combinational wiring; no storage.
// No flow control: the datapath consumes the controls every cycle.
interface mc_ctrl_unit_if;
  logic [5:0] opcode;
  logic       zero;
  logic       sign;
  logic [2:0] state;
  logic [2:0] ALUOp;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       RegWre;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ExtSel;
  logic       mRD;
  logic       mWR;
  logic       DBDataSrc;
  logic       WrRegDSrc;
  logic [1:0] RegDst;
  logic [1:0] PCSrc;

  // Control unit side
  modport master (
    input  opcode, zero, sign,
    output state, ALUOp, PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB,
           ExtSel, mRD, mWR, DBDataSrc, WrRegDSrc, RegDst, PCSrc
  );

  // Datapath side
  modport slave (
    output opcode, zero, sign,
    input  state, ALUOp, PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB,
           ExtSel, mRD, mWR, DBDataSrc, WrRegDSrc, RegDst, PCSrc
  );
endinterface

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control unit: instruction-phase FSM plus opcode decode for the datapath.
// Latency: 2 (jump/nop), 3 (branch), 4 (sw, ALU op), 5 (lw) cycles from IF; outputs are Moore except branch PCSrc.
// No backpressure; halt parks the FSM until the synchronous active-low reset.
module mc_ctrl_unit (
  input  logic          CLK,
  input  logic          RST,
  mc_ctrl_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_halted;
  logic       w_next_halted;

  logic       w_is_alu;
  logic       w_is_rtype;
  logic       w_is_ls;
  logic       w_is_br;
  logic       w_is_halt;
  logic [2:0] w_alu_op;
  logic       w_src_a;
  logic       w_src_b;
  logic       w_ext;
  logic       w_br_taken;

  // State and halted flag; reset wins over every transition, including halt
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= S_IF;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= w_next_halted;
    end
  end

  // Opcode classification and per-instruction operand/ALU controls
  always_comb begin
    w_is_alu   = 1'b0;
    w_is_rtype = 1'b0;
    w_is_ls    = 1'b0;
    w_is_br    = 1'b0;
    w_is_halt  = 1'b0;
    w_alu_op   = 3'b000;
    w_src_a    = 1'b0;
    w_src_b    = 1'b0;
    w_ext      = 1'b0;
    case (bus.opcode)
      OP_ADD:   begin w_is_alu = 1'b1; w_is_rtype = 1'b1; end
      OP_SUB:   begin w_is_alu = 1'b1; w_is_rtype = 1'b1; w_alu_op = 3'b001; end
      OP_ADDIU: begin w_is_alu = 1'b1; w_src_b = 1'b1; w_ext = 1'b1; end
      OP_AND:   begin w_is_alu = 1'b1; w_is_rtype = 1'b1; w_alu_op = 3'b100; end
      OP_ANDI:  begin w_is_alu = 1'b1; w_src_b = 1'b1; w_alu_op = 3'b100; end
      OP_ORI:   begin w_is_alu = 1'b1; w_src_b = 1'b1; w_alu_op = 3'b011; end
      OP_XORI:  begin w_is_alu = 1'b1; w_src_b = 1'b1; w_alu_op = 3'b111; end
      OP_SLL:   begin w_is_alu = 1'b1; w_is_rtype = 1'b1; w_src_a = 1'b1; w_alu_op = 3'b010; end
      OP_SLTI:  begin w_is_alu = 1'b1; w_src_b = 1'b1; w_ext = 1'b1; w_alu_op = 3'b110; end
      OP_SLT:   begin w_is_alu = 1'b1; w_is_rtype = 1'b1; w_alu_op = 3'b110; end
      OP_SW,
      OP_LW:    begin w_is_ls = 1'b1; w_src_b = 1'b1; w_ext = 1'b1; end
      OP_BEQ,
      OP_BNE,
      OP_BLTZ:  begin w_is_br = 1'b1; w_ext = 1'b1; w_alu_op = 3'b001; end
      OP_HALT:  w_is_halt = 1'b1;
      default:  ;
    endcase
  end

  // Branch resolution from the ALU flags (only consumed in EXE_BR)
  always_comb begin
    w_br_taken = 1'b0;
    case (bus.opcode)
      OP_BEQ:  w_br_taken = bus.zero;
      OP_BNE:  w_br_taken = ~bus.zero;
      OP_BLTZ: w_br_taken = bus.sign;
      default: w_br_taken = 1'b0;
    endcase
  end

  // Next-state logic; once halted the FSM stays put
  always_comb begin
    w_next_state  = r_state;
    w_next_halted = r_halted;
    if (!r_halted) begin
      case (r_state)
        S_IF: w_next_state = S_ID;
        S_ID: begin
          if (w_is_halt) begin
            w_next_state  = S_ID;
            w_next_halted = 1'b1;
          end else if (w_is_br) begin
            w_next_state = S_EXE_BR;
          end else if (w_is_ls) begin
            w_next_state = S_EXE_LS;
          end else if (w_is_alu) begin
            w_next_state = S_EXE_AL;
          end else begin
            w_next_state = S_IF;
          end
        end
        S_EXE_LS: w_next_state = S_MEM;
        S_MEM:    w_next_state = (bus.opcode == OP_LW) ? S_WB_LD : S_IF;
        S_WB_LD:  w_next_state = S_IF;
        S_EXE_BR: w_next_state = S_IF;
        S_EXE_AL: w_next_state = S_WB_AL;
        S_WB_AL:  w_next_state = S_IF;
        default:  w_next_state = S_IF;
      endcase
    end
  end

  // Datapath controls; ALU/operand selects are held from ID to the end of the instruction
  always_comb begin
    bus.state     = r_state;
    bus.ALUOp     = 3'b000;
    bus.PCWre     = 1'b0;
    bus.IRWre     = 1'b0;
    bus.InsMemRW  = 1'b0;
    bus.RegWre    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.ExtSel    = 1'b0;
    bus.mRD       = 1'b0;
    bus.mWR       = 1'b0;
    bus.DBDataSrc = 1'b0;
    bus.WrRegDSrc = 1'b0;
    bus.RegDst    = 2'b00;
    bus.PCSrc     = 2'b00;
    if (!r_halted) begin
      if (r_state == S_IF) begin
        bus.IRWre    = 1'b1;
        bus.InsMemRW = 1'b1;
      end else begin
        bus.ALUOp   = w_alu_op;
        bus.ALUSrcA = w_src_a;
        bus.ALUSrcB = w_src_b;
        bus.ExtSel  = w_ext;
        case (r_state)
          S_ID: begin
            if (bus.opcode == OP_J) begin
              bus.PCWre = 1'b1;
              bus.PCSrc = 2'b11;
            end else if (bus.opcode == OP_JR) begin
              bus.PCWre = 1'b1;
              bus.PCSrc = 2'b10;
            end else if (bus.opcode == OP_JAL) begin
              bus.PCWre     = 1'b1;
              bus.PCSrc     = 2'b11;
              bus.RegWre    = 1'b1;
              bus.RegDst    = 2'b00;
              bus.WrRegDSrc = 1'b0;
            end else if (!(w_is_alu || w_is_ls || w_is_br || w_is_halt)) begin
              bus.PCWre = 1'b1;
              bus.PCSrc = 2'b00;
            end
          end
          S_EXE_BR: begin
            bus.PCWre = 1'b1;
            bus.PCSrc = w_br_taken ? 2'b01 : 2'b00;
          end
          S_MEM: begin
            if (bus.opcode == OP_LW) begin
              bus.mRD = 1'b1;
            end else begin
              bus.mWR   = 1'b1;
              bus.PCWre = 1'b1;
            end
          end
          S_WB_LD: begin
            bus.RegWre    = 1'b1;
            bus.RegDst    = 2'b01;
            bus.DBDataSrc = 1'b1;
            bus.WrRegDSrc = 1'b1;
            bus.PCWre     = 1'b1;
          end
          S_WB_AL: begin
            bus.RegWre    = 1'b1;
            bus.WrRegDSrc = 1'b1;
            bus.RegDst    = w_is_rtype ? 2'b10 : 2'b01;
            bus.PCWre     = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Randomized bench for mc_ctrl_unit with a per-instruction reference model and output scoreboard.
// One expected output vector per clock cycle; the monitor compares it on the falling edge.
// Covers reset, every opcode class, random NOP opcodes, mid-instruction reset and halt.
module tb_mc_ctrl_unit;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] aluop;
    logic       pcwre;
    logic       irwre;
    logic       imrw;
    logic       regwre;
    logic       srca;
    logic       srcb;
    logic       ext;
    logic       mrd;
    logic       mwr;
    logic       dbsrc;
    logic       wrsrc;
    logic [1:0] regdst;
    logic [1:0] pcsrc;
  } exp_t;

  localparam int C_NOP = 0, C_J = 1, C_JR = 2, C_JAL = 3, C_BR = 4,
                 C_SW = 5, C_LW = 6, C_ALU = 7, C_HALT = 8;

  logic CLK;
  logic RST;
  mc_ctrl_unit_if bus ();

  mc_ctrl_unit dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  bit   started;
  bit   done;
  int   cyc;
  logic [5:0] ops [18];

  // Instruction class from the opcode table
  function automatic int cls(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
      6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b100111: return C_ALU;
      6'b110000: return C_SW;
      6'b110001: return C_LW;
      6'b110100, 6'b110101, 6'b110110: return C_BR;
      6'b111000: return C_J;
      6'b111001: return C_JR;
      6'b111010: return C_JAL;
      6'b111111: return C_HALT;
      default:   return C_NOP;
    endcase
  endfunction

  // Cycles from IF through the final state
  function automatic int ncyc(input int c);
    case (c)
      C_BR:          return 3;
      C_SW, C_ALU:   return 4;
      C_LW:          return 5;
      default:       return 2;
    endcase
  endfunction

  // Expected output vector for cycle i of an instruction
  function automatic exp_t model(input logic [5:0] op, input int i, input logic z, input logic s);
    exp_t e;
    int   c;
    bit   last;
    bit   rtype;
    e = '0;
    c = cls(op);
    if (i == 0) begin
      e.st = 3'd0; e.irwre = 1'b1; e.imrw = 1'b1;
      return e;
    end
    if (i == 1) e.st = 3'd1;
    else if (c == C_BR) e.st = 3'd5;
    else if (c == C_ALU) e.st = (i == 2) ? 3'd6 : 3'd7;
    else e.st = 3'(i);   // load/store walk 2,3,4
    case (op)
      6'b000001, 6'b110100, 6'b110101, 6'b110110: e.aluop = 3'b001;
      6'b011000: e.aluop = 3'b010;
      6'b010010: e.aluop = 3'b011;
      6'b010000, 6'b010001: e.aluop = 3'b100;
      6'b100110, 6'b100111: e.aluop = 3'b110;
      6'b010011: e.aluop = 3'b111;
      default:   e.aluop = 3'b000;
    endcase
    e.srca = (op == 6'b011000);
    e.srcb = (op inside {6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110, 6'b110000, 6'b110001});
    e.ext  = (op inside {6'b000010, 6'b100110, 6'b110000, 6'b110001, 6'b110100, 6'b110101, 6'b110110});
    rtype  = (op inside {6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100111});
    last   = (i == ncyc(c) - 1) && (c != C_HALT);
    if (last) begin
      e.pcwre = 1'b1;
      if (c == C_J || c == C_JAL) e.pcsrc = 2'b11;
      else if (c == C_JR) e.pcsrc = 2'b10;
      else if (c == C_BR)
        e.pcsrc = ((op == 6'b110100 && z) || (op == 6'b110101 && !z) ||
                   (op == 6'b110110 && s)) ? 2'b01 : 2'b00;
    end
    if (c == C_JAL && last) begin
      e.regwre = 1'b1; e.regdst = 2'b00; e.wrsrc = 1'b0;
    end
    if (c == C_LW && i == 3) e.mrd = 1'b1;
    if (c == C_LW && last) begin
      e.regwre = 1'b1; e.regdst = 2'b01; e.dbsrc = 1'b1; e.wrsrc = 1'b1;
    end
    if (c == C_SW && i == 3) e.mwr = 1'b1;
    if (c == C_ALU && last) begin
      e.regwre = 1'b1; e.wrsrc = 1'b1; e.regdst = rtype ? 2'b10 : 2'b01;
    end
    return e;
  endfunction

  function automatic exp_t halted_exp();
    exp_t e;
    e = '0;
    e.st = 3'd1;
    return e;
  endfunction

  // zmode/smode: 0 or 1 forces the flag in every cycle, 2 randomizes per cycle.
  // abort_at >= 0 pulls RST low during that cycle and abandons the instruction.
  task automatic run_instr(input logic [5:0] op, input int zmode, input int smode, input int abort_at);
    int   n;
    logic z, s;
    n = ncyc(cls(op));
    for (int i = 0; i < n; i++) begin
      z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      s = (smode == 2) ? 1'($urandom) : 1'(smode);
      bus.opcode = (i == 0) ? 6'($urandom) : op;
      bus.zero   = z;
      bus.sign   = s;
      if (i == abort_at) RST = 1'b0;
      exp_q.push_back(model(op, i, z, s));
      @(posedge CLK);
      #1;
      RST = 1'b1;
      if (i == abort_at) break;
    end
  endtask

  // Halt, sit in the halted state for a while, then reset out of it
  task automatic run_halt(input int n_halted);
    run_instr(6'b111111, 2, 2, -1);
    for (int k = 0; k < n_halted; k++) begin
      bus.zero = 1'($urandom);
      bus.sign = 1'($urandom);
      if (k == n_halted - 1) RST = 1'b0;
      exp_q.push_back(halted_exp());
      @(posedge CLK);
      #1;
      RST = 1'b1;
    end
  endtask

  // Monitor: one expected vector per cycle once stimulus has started
  initial begin
    exp_t got;
    exp_t e;
    cyc = 0;
    while (!done) begin
      @(negedge CLK);
      if (started && !done) begin
        cyc++;
        got = {bus.state, bus.ALUOp, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre,
               bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.mRD, bus.mWR, bus.DBDataSrc,
               bus.WrRegDSrc, bus.RegDst, bus.PCSrc};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL underrun cyc=%0d got=%h required=an expected entry", cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL outputs cyc=%0d op=%b state=%b got=%h required=%h",
                     cyc, bus.opcode, bus.state, got, e);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic [5:0] op;
    int         r;
    int         ab;
    checks  = 0;
    errors  = 0;
    started = 1'b0;
    done    = 1'b0;
    ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
            6'b010011, 6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001,
            6'b110100, 6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010};
    RST        = 1'b0;
    bus.opcode = 6'b000000;
    bus.zero   = 1'b0;
    bus.sign   = 1'b0;
    @(posedge CLK);
    #1;
    started = 1'b1;
    exp_q.push_back(model(6'b000000, 0, 1'b0, 1'b0));
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // Directed opening sequence
    run_instr(6'b000000, 2, 2, -1);   // add
    run_instr(6'b110001, 2, 2, -1);   // lw
    run_instr(6'b110100, 1, 2, -1);   // beq taken
    run_instr(6'b110100, 0, 2, -1);   // beq not taken
    run_instr(6'b110110, 2, 1, -1);   // bltz taken
    run_instr(6'b110101, 0, 2, -1);   // bne taken
    run_instr(6'b111010, 2, 2, -1);   // jal
    run_instr(6'b000101, 2, 2, -1);   // undefined -> nop
    run_instr(6'b110000, 2, 2, 3);    // sw with reset in MEM
    run_halt(10);

    // Random mix
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 39);
      if (r == 0) op = 6'b111111;
      else if (r < 10) op = 6'($urandom);
      else op = ops[$urandom_range(0, 17)];
      if (cls(op) == C_HALT) begin
        run_halt($urandom_range(1, 10));
      end else begin
        ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ncyc(cls(op)) - 1) : -1;
        run_instr(op, 2, 2, ab);
      end
    end

    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
